// File: rtl/serial_subtractor_4_bit.sv
// Bit-serial two's-complement subtractor: d = a - b - bin, one bit slice per clock, LSB first.
// A single borrow register is reused across all slices; start/busy/done handshake.
module serial_subtractor_4_bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br;
  logic [CW-1:0]    count;

  logic ai;
  logic bi;
  logic di;
  logic br_next;
  logic last;

  // One full-subtractor slice, selected by the bit counter.
  assign ai      = a_q[count];
  assign bi      = b_q[count];
  assign di      = ai ^ bi ^ br;
  assign br_next = (~ai & bi) | (~(ai ^ bi) & br);
  assign last    = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      br    <= 1'b0;
      count <= '0;
      d     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            br    <= bin;
            count <= '0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          d[count] <= di;
          br       <= br_next;
          count    <= count + 1'b1;
          if (last) begin
            // ovf uses only the latched operand signs and the MSB difference bit.
            count <= '0;
            bout  <= br_next;
            ovf   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (di != a_q[WIDTH-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
